// File: rtl/isp_pic_fetch.sv
// AXI4 read-burst engine: fetches one 32x32x3 picture as three 64-beat bursts
// and streams exposure-scaled 16-pixel beats to the ISP AF/AE core.
module isp_pic_fetch #(
   parameter logic [31:0] BASE_ADDR = 32'h0001_0000,
   parameter int unsigned PIC_BYTES = 3072
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [3:0]   pic_no,
   input  logic         scale_en,
   input  logic [1:0]   ratio_mode,
   output logic         busy,
   output logic         done,
   output logic [3:0]   arid_m_inf,
   output logic [31:0]  araddr_m_inf,
   output logic [7:0]   arlen_m_inf,
   output logic [2:0]   arsize_m_inf,
   output logic [1:0]   arburst_m_inf,
   output logic         arvalid_m_inf,
   input  logic         arready_m_inf,
   input  logic [3:0]   rid_m_inf,
   input  logic [127:0] rdata_m_inf,
   input  logic [1:0]   rresp_m_inf,
   input  logic         rlast_m_inf,
   input  logic         rvalid_m_inf,
   output logic         rready_m_inf,
   output logic         pix_valid,
   input  logic         pix_ready,
   output logic [127:0] pix_data,
   output logic [1:0]   pix_ch,
   output logic [4:0]   pix_row,
   output logic         pix_half
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_AR,
      S_RD,
      S_FLUSH,
      S_DONE
   } state_t;

   state_t      state;
   state_t      state_nx;

   logic [3:0]  pic_q;
   logic        scale_q;
   logic [1:0]  ratio_q;
   logic [1:0]  ch;
   logic [5:0]  beat;
   logic        live;
   logic        rd_fire;
   logic        out_fire;
   logic [31:0] burst_addr;
   logic        unused_ok;

   assign unused_ok = ^{rid_m_inf, rresp_m_inf, rlast_m_inf};

   function automatic logic [127:0] scale_beat(input logic [127:0] d,
                                                input logic en,
                                                input logic [1:0] r);
      logic [7:0] x;
      scale_beat = d;
      if (en) begin
         for (int unsigned k = 0; k < 16; k++) begin
            x = d[8*k +: 8];
            case (r)
               2'd0:    scale_beat[8*k +: 8] = {2'b00, x[7:2]};
               2'd1:    scale_beat[8*k +: 8] = {1'b0, x[7:1]};
               2'd2:    scale_beat[8*k +: 8] = x;
               default: scale_beat[8*k +: 8] = x[7] ? 8'hFF : {x[6:0], 1'b0};
            endcase
         end
      end
   endfunction

   always_comb begin
      rd_fire    = (state == S_RD) && rvalid_m_inf && rready_m_inf;
      out_fire   = pix_valid && pix_ready;
      burst_addr = BASE_ADDR + (32'(pic_q) * PIC_BYTES) + {20'd0, ch, 10'd0};
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   // Next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (start) state_nx = S_AR;
         S_AR:    if (arvalid_m_inf && arready_m_inf) state_nx = S_RD;
         S_RD:    if (rd_fire && (beat == 6'd63)) state_nx = (ch < 2'd2) ? S_AR : S_FLUSH;
         S_FLUSH: if (out_fire) state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Output decode; constant AXI fields stay 0 until the first edge after reset
   always_comb begin
      busy          = (state != S_IDLE);
      done          = (state == S_DONE);
      arvalid_m_inf = (state == S_AR);
      araddr_m_inf  = (state == S_AR) ? burst_addr : '0;
      rready_m_inf  = (state == S_RD) && (!pix_valid || pix_ready);
      arid_m_inf    = '0;
      arlen_m_inf   = live ? 8'd63 : '0;
      arsize_m_inf  = live ? 3'b100 : '0;
      arburst_m_inf = live ? 2'b01 : '0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) live <= 1'b0;
      else        live <= 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pic_q   <= '0;
         scale_q <= 1'b0;
         ratio_q <= '0;
         ch      <= '0;
         beat    <= '0;
      end else if ((state == S_IDLE) && start) begin
         pic_q   <= pic_no;
         scale_q <= scale_en;
         ratio_q <= ratio_mode;
         ch      <= '0;
         beat    <= '0;
      end else if (rd_fire) begin
         if (beat == 6'd63) begin
            beat <= '0;
            if (ch < 2'd2) ch <= ch + 2'd1;
         end else begin
            beat <= beat + 6'd1;
         end
      end
   end

   // One-entry output register; refill only when empty or being accepted
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pix_valid <= 1'b0;
         pix_data  <= '0;
         pix_ch    <= '0;
         pix_row   <= '0;
         pix_half  <= 1'b0;
      end else if (rd_fire) begin
         pix_valid <= 1'b1;
         pix_data  <= scale_beat(rdata_m_inf, scale_q, ratio_q);
         pix_ch    <= ch;
         pix_row   <= beat[5:1];
         pix_half  <= beat[0];
      end else if (out_fire) begin
         pix_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_isp_pic_fetch.sv
// Directed bench for isp_pic_fetch with a resettable AXI DRAM responder model.
module tb_isp_pic_fetch;

   localparam logic [31:0] BASE = 32'h0001_0000;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start = 1'b0;
   logic [3:0]   pic_no = '0;
   logic         scale_en = 1'b0;
   logic [1:0]   ratio_mode = '0;
   logic         busy, done;
   logic [3:0]   arid_m_inf;
   logic [31:0]  araddr_m_inf;
   logic [7:0]   arlen_m_inf;
   logic [2:0]   arsize_m_inf;
   logic [1:0]   arburst_m_inf;
   logic         arvalid_m_inf;
   logic         arready_m_inf;
   logic [3:0]   rid_m_inf;
   logic [127:0] rdata_m_inf;
   logic [1:0]   rresp_m_inf;
   logic         rlast_m_inf;
   logic         rvalid_m_inf;
   logic         rready_m_inf;
   logic         pix_valid;
   logic         pix_ready = 1'b0;
   logic [127:0] pix_data;
   logic [1:0]   pix_ch;
   logic [4:0]   pix_row;
   logic         pix_half;

   isp_pic_fetch #(.BASE_ADDR(32'h0001_0000), .PIC_BYTES(3072)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .pic_no(pic_no),
      .scale_en(scale_en), .ratio_mode(ratio_mode), .busy(busy), .done(done),
      .arid_m_inf(arid_m_inf), .araddr_m_inf(araddr_m_inf), .arlen_m_inf(arlen_m_inf),
      .arsize_m_inf(arsize_m_inf), .arburst_m_inf(arburst_m_inf),
      .arvalid_m_inf(arvalid_m_inf), .arready_m_inf(arready_m_inf),
      .rid_m_inf(rid_m_inf), .rdata_m_inf(rdata_m_inf), .rresp_m_inf(rresp_m_inf),
      .rlast_m_inf(rlast_m_inf), .rvalid_m_inf(rvalid_m_inf), .rready_m_inf(rready_m_inf),
      .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
      .pix_ch(pix_ch), .pix_row(pix_row), .pix_half(pix_half)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   bit rand_mode = 1'b0;

   always @(posedge clk) cyc++;

   // Each DRAM byte is (addr[7:0] ^ addr[15:8])
   function automatic logic [127:0] pat(input logic [31:0] a);
      logic [31:0] b;
      for (int k = 0; k < 16; k++) begin
         b = a + 32'(k);
         pat[8*k +: 8] = b[7:0] ^ b[15:8];
      end
   endfunction

   function automatic logic [7:0] sc(input logic [7:0] x, input int rm);
      case (rm)
         0:       sc = x / 8'd4;
         1:       sc = x / 8'd2;
         2:       sc = x;
         default: sc = (x > 8'd127) ? 8'd255 : 8'(x * 2);
      endcase
   endfunction

   function automatic logic [127:0] exp_beat(input int p, input bit se, input int rm, input int i);
      logic [31:0]  a;
      logic [127:0] raw;
      a   = BASE + 32'(p) * 32'd3072 + 32'(i / 64) * 32'd1024 + 32'(i % 64) * 32'd16;
      raw = pat(a);
      exp_beat = raw;
      if (se) for (int k = 0; k < 16; k++) exp_beat[8*k +: 8] = sc(raw[8*k +: 8], rm);
   endfunction

   // DRAM responder
   logic        m_busy;
   logic [31:0] m_addr;
   logic [6:0]  m_beat;
   assign rid_m_inf   = '0;
   assign rresp_m_inf = '0;
   assign rlast_m_inf = rvalid_m_inf && (m_beat == 7'd63);

   always @(posedge clk or negedge rst_n) begin : dram
      logic [6:0] nb;
      if (!rst_n) begin
         m_busy <= 1'b0; m_addr <= '0; m_beat <= '0;
         arready_m_inf <= 1'b0; rvalid_m_inf <= 1'b0; rdata_m_inf <= '0;
      end else if (!m_busy) begin
         rvalid_m_inf <= 1'b0;
         if (arvalid_m_inf && arready_m_inf) begin
            m_busy <= 1'b1; m_addr <= araddr_m_inf; m_beat <= '0; arready_m_inf <= 1'b0;
         end else begin
            arready_m_inf <= rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
         end
      end else begin
         nb = (rvalid_m_inf && rready_m_inf) ? m_beat + 7'd1 : m_beat;
         if (rvalid_m_inf && rready_m_inf && m_beat == 7'd63) begin
            m_busy <= 1'b0; rvalid_m_inf <= 1'b0;
            arready_m_inf <= rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
         end else begin
            m_beat <= nb;
            if (!(rvalid_m_inf && !rready_m_inf)) begin
               rvalid_m_inf <= rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
               rdata_m_inf  <= pat(m_addr + 32'(nb) * 32'd16);
            end
         end
      end
   end

   always @(posedge clk) begin
      #1;
      pix_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Monitor: records handshakes and protocol violations on the falling edge
   logic [127:0] cap_data [0:2047];
   logic [1:0]   cap_ch   [0:2047];
   logic [4:0]   cap_row  [0:2047];
   logic         cap_half [0:2047];
   int           cap_cyc  [0:2047];
   logic [31:0]  ar_addr  [0:63];
   int acc_cnt = 0, ar_cnt = 0, done_cnt = 0, done_cyc = 0, viol = 0, stall_cnt = 0;
   bit prev_stall = 1'b0;
   logic [127:0] sv_data;
   logic [1:0]   sv_ch;
   logic [4:0]   sv_row;
   logic         sv_half;

   always @(negedge clk) begin
      if (!rst_n) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall && (!pix_valid || pix_data !== sv_data || pix_ch !== sv_ch ||
                            pix_row !== sv_row || pix_half !== sv_half)) viol++;
         if (pix_valid && !pix_ready && rready_m_inf) viol++;
         if (arvalid_m_inf && rready_m_inf) viol++;
         if (pix_valid && !pix_ready) stall_cnt++;
         prev_stall = pix_valid && !pix_ready;
         sv_data = pix_data; sv_ch = pix_ch; sv_row = pix_row; sv_half = pix_half;
         if (arvalid_m_inf && arready_m_inf) begin
            if (ar_cnt < 64) ar_addr[ar_cnt] = araddr_m_inf;
            ar_cnt++;
         end
         if (pix_valid && pix_ready) begin
            if (acc_cnt < 2048) begin
               cap_data[acc_cnt] = pix_data; cap_ch[acc_cnt] = pix_ch;
               cap_row[acc_cnt] = pix_row; cap_half[acc_cnt] = pix_half;
               cap_cyc[acc_cnt] = cyc;
            end
            acc_cnt++;
         end
         if (done) begin done_cnt++; done_cyc = cyc; end
      end
   end

   task automatic pulse_start(input logic [3:0] p, input logic se, input logic [1:0] rm);
      @(posedge clk); #1;
      start = 1'b1; pic_no = p; scale_en = se; ratio_mode = rm;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Returns on the falling edge after the one seen with done high
   task automatic wait_done(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 6000; i++) begin
         @(negedge clk);
         if (done) begin ok = 1'b1; break; end
      end
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      #2;
      total++;
      if ({busy, done, arvalid_m_inf, araddr_m_inf, rready_m_inf, pix_valid, pix_data,
           pix_ch, pix_row, pix_half, arid_m_inf, arlen_m_inf, arsize_m_inf, arburst_m_inf} !== '0)
         begin bad++; $display("FAIL reset_outputs: got nonzero output, want all 0"); end
      repeat (3) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(negedge clk);
      total++;
      if ({arid_m_inf, arlen_m_inf, arsize_m_inf, arburst_m_inf} !== {4'd0, 8'd63, 3'b100, 2'b01}) begin
         bad++; $display("FAIL axi_consts: got %h %h %h %h want 0 3f 4 1",
                         arid_m_inf, arlen_m_inf, arsize_m_inf, arburst_m_inf);
      end
      total++;
      if (busy !== 1'b0 || arvalid_m_inf !== 1'b0) begin
         bad++; $display("FAIL idle_after_reset: got busy=%b arvalid=%b want 0 0", busy, arvalid_m_inf);
      end
   endtask

   task automatic test_focus;
      int b0, a0, d0; bit ok;
      b0 = acc_cnt; a0 = ar_cnt; d0 = done_cnt;
      pulse_start(4'd0, 1'b0, 2'd3);
      total++;
      if (busy !== 1'b1 || arvalid_m_inf !== 1'b1 || araddr_m_inf !== 32'h0001_0000) begin
         bad++; $display("FAIL start_latency: got busy=%b arvalid=%b addr=%h want 1 1 00010000",
                         busy, arvalid_m_inf, araddr_m_inf);
      end
      wait_done(ok);
      total++; if (!ok) begin bad++; $display("FAIL focus_done_timeout: got none want done"); end
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL done_pulse: got done=%b busy=%b want 0 0", done, busy);
      end
      total++;
      if (ar_cnt - a0 !== 3) begin bad++; $display("FAIL focus_ar_count: got %0d want 3", ar_cnt - a0); end
      for (int i = 0; i < 3; i++) begin
         total++;
         if (ar_addr[a0 + i] !== 32'h0001_0000 + 32'(i) * 32'h400) begin
            bad++; $display("FAIL focus_araddr%0d: got %h want %h", i, ar_addr[a0 + i],
                            32'h0001_0000 + 32'(i) * 32'h400);
         end
      end
      total++;
      if (acc_cnt - b0 !== 192) begin bad++; $display("FAIL focus_beats: got %0d want 192", acc_cnt - b0); end
      for (int i = 0; i < 192; i++) begin
         total++;
         if (cap_data[b0 + i] !== exp_beat(0, 1'b0, 0, i)) begin
            bad++; $display("FAIL focus_data%0d: got %h want %h", i, cap_data[b0 + i], exp_beat(0, 1'b0, 0, i));
         end
         total++;
         if ({cap_ch[b0 + i], cap_row[b0 + i], cap_half[b0 + i]} !== {2'(i / 64), 5'((i % 64) / 2), 1'(i % 2)}) begin
            bad++; $display("FAIL focus_tag%0d: got ch=%0d row=%0d half=%0d", i,
                            cap_ch[b0 + i], cap_row[b0 + i], cap_half[b0 + i]);
         end
      end
      total++;
      if (done_cyc !== cap_cyc[b0 + 191] + 1) begin
         bad++; $display("FAIL done_latency: got cycle %0d want %0d", done_cyc, cap_cyc[b0 + 191] + 1);
      end
      total++;
      if (cap_cyc[b0 + 63] - cap_cyc[b0] !== 63) begin
         bad++; $display("FAIL back_to_back: got span %0d want 63", cap_cyc[b0 + 63] - cap_cyc[b0]);
      end
      total++;
      if (done_cnt - d0 !== 1) begin bad++; $display("FAIL focus_done_count: got %0d want 1", done_cnt - d0); end
   endtask

   task automatic test_ratio3;
      int b0, a0; bit ok;
      logic [31:0]  exp_a [0:2];
      logic [127:0] t;
      exp_a[0] = 32'h0001_B400; exp_a[1] = 32'h0001_B800; exp_a[2] = 32'h0001_BC00;
      b0 = acc_cnt; a0 = ar_cnt;
      pulse_start(4'd15, 1'b1, 2'd3);
      wait_done(ok);
      total++; if (!ok) begin bad++; $display("FAIL r3_done_timeout: got none want done"); end
      for (int i = 0; i < 3; i++) begin
         total++;
         if (ar_addr[a0 + i] !== exp_a[i]) begin
            bad++; $display("FAIL r3_araddr%0d: got %h want %h", i, ar_addr[a0 + i], exp_a[i]);
         end
      end
      t = cap_data[b0 + 3];
      total++; if (t[39:32] !== 8'hFF) begin bad++; $display("FAIL sat_0x80: got %h want ff", t[39:32]); end
      t = cap_data[b0 + 12];
      total++; if (t[95:88] !== 8'hFE) begin bad++; $display("FAIL dbl_0x7f: got %h want fe", t[95:88]); end
      for (int i = 0; i < 192; i++) begin
         total++;
         if (cap_data[b0 + i] !== exp_beat(15, 1'b1, 3, i)) begin
            bad++; $display("FAIL r3_data%0d: got %h want %h", i, cap_data[b0 + i], exp_beat(15, 1'b1, 3, i));
         end
      end
   endtask

   task automatic test_ratios;
      int b0, a0; bit ok;
      logic [7:0]   exp_b [0:2];
      logic [127:0] t;
      exp_b[0] = 8'h3F; exp_b[1] = 8'h7F; exp_b[2] = 8'hFF;
      for (int rm = 0; rm < 3; rm++) begin
         b0 = acc_cnt; a0 = ar_cnt;
         pulse_start(4'd5, 1'b1, 2'(rm));
         wait_done(ok);
         total++; if (!ok) begin bad++; $display("FAIL ratio%0d_done_timeout: got none want done", rm); end
         total++;
         if (ar_addr[a0] !== 32'h0001_3C00) begin
            bad++; $display("FAIL ratio%0d_araddr: got %h want 00013c00", rm, ar_addr[a0]);
         end
         t = cap_data[b0 + 12];
         total++;
         if (t[31:24] !== exp_b[rm]) begin
            bad++; $display("FAIL ratio%0d_byte_ff: got %h want %h", rm, t[31:24], exp_b[rm]);
         end
         for (int i = 0; i < 192; i++) begin
            total++;
            if (cap_data[b0 + i] !== exp_beat(5, 1'b1, rm, i)) begin
               bad++; $display("FAIL ratio%0d_data%0d: got %h want %h", rm, i, cap_data[b0 + i],
                               exp_beat(5, 1'b1, rm, i));
            end
         end
      end
   endtask

   task automatic test_random_stall;
      int b0, v0, s0; bit ok;
      b0 = acc_cnt; v0 = viol; s0 = stall_cnt;
      rand_mode = 1'b1;
      pulse_start(4'd7, 1'b1, 2'd1);
      wait_done(ok);
      rand_mode = 1'b0;
      repeat (4) @(negedge clk);
      total++; if (!ok) begin bad++; $display("FAIL rand_done_timeout: got none want done"); end
      total++;
      if (acc_cnt - b0 !== 192) begin bad++; $display("FAIL rand_beats: got %0d want 192", acc_cnt - b0); end
      total++;
      if (viol - v0 !== 0) begin bad++; $display("FAIL rand_protocol: got %0d violations want 0", viol - v0); end
      total++;
      if (stall_cnt - s0 == 0) begin bad++; $display("FAIL rand_stalls: got 0 stall cycles want >0"); end
      for (int i = 0; i < 192; i++) begin
         total++;
         if (cap_data[b0 + i] !== exp_beat(7, 1'b1, 1, i) ||
             {cap_ch[b0 + i], cap_row[b0 + i], cap_half[b0 + i]} !== {2'(i / 64), 5'((i % 64) / 2), 1'(i % 2)}) begin
            bad++; $display("FAIL rand_beat%0d: got %h ch=%0d row=%0d want %h", i, cap_data[b0 + i],
                            cap_ch[b0 + i], cap_row[b0 + i], exp_beat(7, 1'b1, 1, i));
         end
      end
   endtask

   task automatic test_restart_ignored;
      int b0, a0, d0; bit ok;
      b0 = acc_cnt; a0 = ar_cnt; d0 = done_cnt;
      pulse_start(4'd4, 1'b0, 2'd2);
      repeat (5) @(posedge clk);
      pulse_start(4'd9, 1'b1, 2'd0);
      wait_done(ok);
      repeat (30) @(negedge clk);
      total++; if (!ok) begin bad++; $display("FAIL restart_done_timeout: got none want done"); end
      total++;
      if (ar_cnt - a0 !== 3) begin bad++; $display("FAIL restart_ar_count: got %0d want 3", ar_cnt - a0); end
      total++;
      if (done_cnt - d0 !== 1) begin bad++; $display("FAIL restart_done_count: got %0d want 1", done_cnt - d0); end
      total++;
      if (ar_addr[a0 + 2] !== 32'h0001_3800) begin
         bad++; $display("FAIL restart_araddr: got %h want 00013800", ar_addr[a0 + 2]);
      end
      for (int i = 0; i < 192; i++) begin
         total++;
         if (cap_data[b0 + i] !== exp_beat(4, 1'b0, 0, i)) begin
            bad++; $display("FAIL restart_data%0d: got %h want %h", i, cap_data[b0 + i], exp_beat(4, 1'b0, 0, i));
         end
      end
   endtask

   task automatic test_reset_mid;
      int b0, a0; bit ok, hit;
      b0 = acc_cnt;
      pulse_start(4'd3, 1'b0, 2'd2);
      hit = 1'b0;
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if (acc_cnt - b0 >= 70) begin hit = 1'b1; break; end
      end
      total++; if (!hit) begin bad++; $display("FAIL mid_reach70_timeout: got %0d beats want 70", acc_cnt - b0); end
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      total++;
      if ({busy, done, arvalid_m_inf, araddr_m_inf, rready_m_inf, pix_valid, pix_data,
           pix_ch, pix_row, pix_half, arlen_m_inf, arsize_m_inf, arburst_m_inf} !== '0)
         begin bad++; $display("FAIL mid_reset_outputs: got busy=%b pix_valid=%b data=%h want all 0",
                               busy, pix_valid, pix_data); end
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      repeat (2) @(negedge clk);
      b0 = acc_cnt; a0 = ar_cnt;
      pulse_start(4'd2, 1'b1, 2'd0);
      wait_done(ok);
      total++; if (!ok) begin bad++; $display("FAIL pic2_done_timeout: got none want done"); end
      total++;
      if (acc_cnt - b0 !== 192) begin bad++; $display("FAIL pic2_beats: got %0d want 192", acc_cnt - b0); end
      total++;
      if (ar_addr[a0] !== 32'h0001_1800) begin bad++; $display("FAIL pic2_araddr: got %h want 00011800", ar_addr[a0]); end
      for (int i = 0; i < 192; i++) begin
         total++;
         if (cap_data[b0 + i] !== exp_beat(2, 1'b1, 0, i)) begin
            bad++; $display("FAIL pic2_data%0d: got %h want %h", i, cap_data[b0 + i], exp_beat(2, 1'b1, 0, i));
         end
      end
   endtask

   initial begin
      test_reset();
      test_focus();
      test_ratio3();
      test_ratios();
      test_random_stall();
      test_restart_ignored();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/isp_pic_fetch.md
# isp_pic_fetch

AXI4 read-burst engine that fetches one 32x32x3 picture from DRAM and streams it, 16 pixels per beat, to the ISP auto-focus/auto-exposure core. It sits between the DRAM AXI read channels and the ISP datapath. It applies the auto-exposure ratio scaling on the fly, so the core always receives exposure-corrected pixels.

## Interface
Parameters:
- `BASE_ADDR`, default 32'h0001_0000: DRAM address of picture 0, channel R, pixel (0,0).
- `PIC_BYTES`, default 3072: bytes per picture (3 channels x 1024).

Ports:
- `clk` input 1: single clock, all logic on its rising edge.
- `rst_n` input 1: asynchronous active-low reset.
- `start` input 1: one-cycle request pulse.
- `pic_no` input 4: picture index 0..15, sampled with `start`.
- `scale_en` input 1: 1 = exposure mode (apply ratio), 0 = focus mode (raw pass-through). Sampled with `start`.
- `ratio_mode` input 2: 0 = x0.25, 1 = x0.5, 2 = x1, 3 = x2. Sampled with `start`.
- `busy` output 1: high from the cycle after an accepted `start` until `done`, inclusive.
- `done` output 1: one-cycle pulse after the final pixel beat is accepted.
- `arid_m_inf` output 4: constant 0.
- `araddr_m_inf` output 32: burst start address.
- `arlen_m_inf` output 8: constant 63 (64 beats).
- `arsize_m_inf` output 3: constant 3'b100 (16 bytes).
- `arburst_m_inf` output 2: constant 2'b01 (INCR).
- `arvalid_m_inf` output 1: address valid.
- `arready_m_inf` input 1: address ready.
- `rid_m_inf` input 4: ignored.
- `rdata_m_inf` input 128: read data.
- `rresp_m_inf` input 2: ignored.
- `rlast_m_inf` input 1: ignored. The beat counter defines the burst end.
- `rvalid_m_inf` input 1: read data valid.
- `rready_m_inf` output 1: read data ready.
- `pix_valid` output 1: pixel beat valid.
- `pix_ready` input 1: downstream accepts the pixel beat.
- `pix_data` output 128: 16 scaled pixels. Byte k (bits 8k+7:8k) is column `16*pix_half + k`.
- `pix_ch` output 2: channel, 0 = R, 1 = G, 2 = B.
- `pix_row` output 5: row 0..31.
- `pix_half` output 1: 0 = columns 0-15, 1 = columns 16-31.

## Operation
State machine: IDLE -> AR -> RD -> (AR for next channel | FLUSH) -> DONE -> IDLE.

- IDLE
  - `start` = 1 latches `pic_no`, `scale_en` and `ratio_mode`, clears channel counter `ch` and beat counter `beat`, then goes to AR.
  - `start` in any other state is ignored.
- AR
  - `arvalid_m_inf` = 1 and `araddr_m_inf = BASE_ADDR + pic_no*PIC_BYTES + ch*1024`.
  - Address, len, size and burst are held stable until `arvalid_m_inf & arready_m_inf`, then go to RD.
  - Each burst is 1 KB and 1 KB-aligned, so no burst crosses a 4 KB boundary.
- RD
  - `rready_m_inf = !pix_valid | pix_ready`, a one-entry output register with bypass-free refill.
  - On each `rvalid_m_inf & rready_m_inf`, the output register loads the scaled beat, `pix_ch = ch`, `pix_row = beat[5:1]` and `pix_half = beat[0]`, and `beat` increments.
  - When beat 63 is loaded: `beat` clears. If `ch < 2`, `ch` increments and the FSM goes to AR. Otherwise it goes to FLUSH.
- FLUSH: wait until the last beat is accepted (`pix_valid & pix_ready`), then go to DONE.
- DONE: `done` = 1 for one cycle, then go to IDLE.
- `pix_valid` drops on acceptance when no new beat loads in the same cycle.

Only one burst is outstanding at a time. `arvalid_m_inf` is never high in RD.

Scaling is per byte x, applied only if `scale_en` = 1:
- ratio 0: x>>2
- ratio 1: x>>1
- ratio 2: x
- ratio 3: x[7] ? 255 : x<<1 (saturating)

All results are 8 bits with no rounding.

## Timing
- Reset values: every output is 0 (`busy`, `done`, `arvalid_m_inf`, `araddr_m_inf`, `rready_m_inf`, `pix_valid`, `pix_data`, `pix_ch`, `pix_row`, `pix_half`). The constant AXI fields are also 0 during reset and take their constant values after reset.
- `start` sampled at edge T: `arvalid_m_inf` and `busy` are high from T+1.
- A read beat handshaked at edge E appears on `pix_valid`/`pix_data` from E+1.
- With zero-wait-state DRAM and `pix_ready` = 1, an R beat is accepted every cycle.
- `done` rises the cycle after the final pixel handshake. `busy` falls with `done`.
- A new `start` is accepted in the cycle after `done` (IDLE).
- Reset asserted mid-operation returns everything to IDLE at once. Any outstanding AXI transaction is abandoned; the bench resets the DRAM model together with this block.
- `pix_ready` low holds `pix_data`, `pix_ch`, `pix_row` and `pix_half` stable and drops `rready_m_inf` in the same cycle.

## Test plan
- Picture 0, focus mode, `pix_ready` = 1, zero-wait DRAM → three AR handshakes at 0x10000, 0x10400 and 0x10800; 192 beats output in order; `pix_data` equals the raw DRAM bytes; `done` comes 1 cycle after the last beat.
- Picture 15, exposure mode, ratio 3 → `araddr_m_inf` = 0x1B400, 0x1B800, 0x1BC00. A byte of 0x80 outputs 0xFF; a byte of 0x7F outputs 0xFE.
- Exposure mode, ratio 0 and ratio 1 on picture 5 → byte 0xFF outputs 0x3F and 0x7F respectively; ratio 2 outputs 0xFF.
- Random `pix_ready` (50%) and random `arready_m_inf`/`rvalid_m_inf` delays → no beat lost or duplicated; outputs stable while stalled; `rready_m_inf` low whenever `pix_valid & !pix_ready`.
- `start` pulsed again while busy → ignored: only 3 bursts issued, one `done` pulse.
- Reset asserted after 70 beats → all outputs 0 in the same cycle. A fresh `start` then completes picture 2 correctly.
